// File: rtl/cu_pkg.sv
// cu_pkg: shared unit IDs, control-word field positions, states and opcodes for control_unit.
package cu_pkg;
    localparam logic [4:0] ID_A = 5'd0, ID_B = 5'd1, ID_R0 = 5'd2, ID_R1 = 5'd3;
    localparam logic [4:0] ID_IR0 = 5'd4, ID_IR1 = 5'd5;
    localparam logic [4:0] ID_PORTA = 5'd6, ID_PORTB = 5'd7, ID_PORTC = 5'd8, ID_PORTD = 5'd9;
    localparam logic [4:0] ID_AR0 = 5'd10, ID_AR1 = 5'd11, ID_PC0 = 5'd12, ID_PC1 = 5'd13;
    localparam logic [4:0] ID_SP0 = 5'd14, ID_SP1 = 5'd15, ID_M = 5'd16;

    localparam logic [1:0] AMID_PC = 2'd0, AMID_AR = 2'd1, AMID_SP = 2'd2, AMID_R0R1 = 2'd3;

    localparam int ALU_LSB = 53, MID_LSB = 48, SID_LSB = 43, AMID_LSB = 41;
    localparam int OE_AR_BIT = 40, OE_PC_BIT = 39, OE_SP_BIT = 38, OE_R0R1_BIT = 37;
    localparam int OE_SR_BIT = 36, OE_ALU_BIT = 35, PC_INR_BIT = 34;
    localparam int OE_LSB = 17, WE_LSB = 0;

    typedef enum logic [2:0] {
        S_F0   = 3'd0,
        S_F1   = 3'd1,
        S_F2   = 3'd2,
        S_F3   = 3'd3,
        S_DEC  = 3'd4,
        S_EX   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    localparam logic [2:0] CL_MOVI = 3'd0, CL_MOV = 3'd1, CL_ALU = 3'd2, CL_LDAR = 3'd3;
    localparam logic [7:0] OP_HLT = 8'hFF;

    function automatic logic valid_id(input logic [4:0] id);
        return id <= ID_M;
    endfunction
endpackage

// File: rtl/cu_id_decode.sv
// cu_id_decode: maps a unit ID to a one-hot enable vector (bit 16-k for ID k); invalid IDs give 0.
module cu_id_decode
    import cu_pkg::*;
(
    input  logic [4:0]  id,
    input  logic        en,
    output logic [16:0] hot
);
    assign hot = (en && valid_id(id)) ? 17'd1 << (ID_M - id) : 17'd0;
endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired fetch/decode/execute microsequencer driving the CPU control bus.
module control_unit
    import cu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  ir0,
    input  logic [7:0]  ir1,
    output logic [63:0] control_bus,
    output logic        halt,
    output logic [2:0]  state
);
    state_t      cur, nxt;
    logic        armed;
    logic [2:0]  cls;
    logic [4:0]  d, s, src_id, dst_id;
    logic        fetch, is_ex, movi_ok, mov_ok, alu, ldar, mem, src_en, dst_en;
    logic [16:0] oe_hot, we_hot;
    logic [63:0] word;
    logic        unused_ir1;

    assign cls = ir0[7:5];
    assign d = ir0[4:0];
    assign s = ir1[4:0];
    assign unused_ir1 = ^ir1[7:5];

    // armed is clear for one edge after reset so the first F0 word follows release
    always_comb begin
        nxt = S_F0;
        if (armed)
            case (cur)
                S_F0:    nxt = S_F1;
                S_F1:    nxt = S_F2;
                S_F2:    nxt = S_F3;
                S_F3:    nxt = S_DEC;
                S_DEC:   nxt = (ir0 == OP_HLT) ? S_HALT : S_EX;
                S_EX:    nxt = S_F0;
                default: nxt = S_HALT;
            endcase
    end

    assign fetch = nxt inside {S_F0, S_F1, S_F2, S_F3};
    assign is_ex = nxt == S_EX;
    assign movi_ok = is_ex && cls == CL_MOVI && valid_id(d);
    assign mov_ok = is_ex && cls == CL_MOV && valid_id(s) && valid_id(d);
    assign alu = is_ex && cls == CL_ALU;
    assign ldar = is_ex && cls == CL_LDAR;
    assign mem = (movi_ok && d == ID_M) || (mov_ok && (s == ID_M || d == ID_M));
    assign src_en = fetch || movi_ok || mov_ok || ldar;
    assign src_id = fetch ? ID_M : mov_ok ? s : ID_IR1;
    assign dst_en = nxt == S_F1 || nxt == S_F3 || movi_ok || mov_ok || alu || ldar;
    assign dst_id = nxt == S_F1 ? ID_IR0 : nxt == S_F3 ? ID_IR1 : alu ? ID_A : ldar ? ID_AR0 : d;

    cu_id_decode u_src (.id(src_id), .en(src_en), .hot(oe_hot));
    cu_id_decode u_dst (.id(dst_id), .en(dst_en), .hot(we_hot));

    always_comb begin
        word = '0;
        word[ALU_LSB +: 5] = alu ? d : 5'd0;
        word[MID_LSB +: 5] = movi_ok ? ID_IR1 : mov_ok ? s : 5'd0;
        word[SID_LSB +: 5] = (movi_ok || mov_ok) ? d : ldar ? ID_AR0 : 5'd0;
        word[AMID_LSB +: 2] = mem ? AMID_AR : AMID_PC;
        word[OE_AR_BIT] = mem;
        word[OE_PC_BIT] = fetch;
        word[OE_ALU_BIT] = alu;
        word[PC_INR_BIT] = nxt == S_F1 || nxt == S_F3;
        word[OE_LSB +: 17] = oe_hot;
        word[WE_LSB +: 17] = we_hot;
    end

    always_ff @(negedge clk) begin
        if (!reset) begin
            cur <= S_F0;
            armed <= 1'b0;
            control_bus <= '0;
        end else begin
            cur <= nxt;
            armed <= 1'b1;
            control_bus <= word;
        end
    end

    assign halt = cur == S_HALT;
    assign state = cur;
endmodule
